freq_count_bcd: RTL and testbench
=================================

Name: freq_count_bcd

Overview:
- Upstream feeder for the four-digit seven-segment display controller.
- Counts rising edges of a prescaled ring-oscillator signal over a fixed gate window of clk cycles.
- Holds the count in a 4-digit BCD counter and latches it into four 4-bit digit codes at the end of each window.
- dig0..dig3 connect directly to the display controller's in0..in3 inputs.

Parameters:
GATE_CYCLES, 100000000, gate window length in clk cycles (1 s at 100 MHz); minimum 2
GATE_W, 27, width of gate counter; must satisfy 2^GATE_W >= GATE_CYCLES
BLANK_LZ, 1, 1 = blank leading zeros on dig3..dig1; 0 = show all zeros

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
run  input  1  1 = measure continuously; 0 = stop and hold the display
osc_in  input  1  oscillator signal, asynchronous to clk; prescaled upstream to below clk/2
dig0  output  4  units digit code (to display in0)
dig1  output  4  tens digit code (to display in1)
dig2  output  4  hundreds digit code (to display in2)
dig3  output  4  thousands digit code (to display in3)
done  output  1  one-cycle pulse when dig0..dig3 update
overflow  output  1  1 = last completed window exceeded 9999 edges
busy  output  1  1 while in GATE

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous and active-high, sampled on posedge clk, and overrides everything else.
- Reset values:
  - dig0..dig3 = 4'hC (dash code).
  - done = 0, overflow = 0, busy = 0.
  - state = IDLE; gate counter, BCD counter and sync flops cleared.
- Digit code meanings (display controller convention):
  - 0-9 = numeral; 4'hA = "E"; 4'hB = blank; 4'hC-F = dash.
- Input synchronizer:
  - osc_in passes through three flops s1 -> s2 -> s3.
  - rise = s2 & ~s3.
  - An osc_in edge produces rise 2-3 clk later.
- FSM: IDLE, GATE, LATCH.
  - IDLE:
    - Gate counter and BCD counter held at 0; busy = 0.
    - run = 1 -> GATE on the next edge.
  - GATE:
    - busy = 1; gate counter increments every cycle.
    - Every cycle with rise = 1 increments the BCD counter. Digit 0 is least significant; digit 9 wraps to 0 and carries in the same cycle.
    - rise at count 9999: counter saturates at 9999 and the sticky ovf flag is set.
    - gate counter == GATE_CYCLES-1 -> LATCH. A rise in this last cycle is counted, so exactly GATE_CYCLES cycles are sampled.
    - run = 0 -> IDLE immediately: window aborted, no done, outputs hold their last values.
  - LATCH (exactly 1 cycle):
    - On the edge leaving LATCH, registered outputs update and done = 1 for that one cycle.
    - BCD counter, ovf and gate counter are cleared.
    - rise during LATCH is discarded: one dead cycle per window.
    - Next state is GATE if run = 1, else IDLE.
- Output encoding at latch:
  - ovf = 1: dig3 = 4'hA, dig2..dig0 = 4'hB, overflow = 1.
  - ovf = 0: digits = BCD value, overflow = 0.
  - If BLANK_LZ = 1, each leading zero scanning dig3 -> dig1 is replaced by 4'hB. dig0 is never blanked; zero edges gives B,B,B,0.
- Measurement rate:
  - Steady-state window period = GATE_CYCLES + 1 clk (GATE plus LATCH).
  - Edge inputs faster than clk/2 are out of spec; there is no requirement on the count for them.
- Reset mid-window: the next cycle shows reset values; no done pulse.

Test Plan:
- Reset: assert reset 2 cycles with osc_in toggling -> dig3..dig0 = C,C,C,C, done = 0, overflow = 0, busy = 0. run = 0 for 50 cycles -> still IDLE, busy = 0.
- Basic count: GATE_CYCLES = 200, BLANK_LZ = 1. Drive 37 clean rising edges spaced 4 clk, all inside GATE. Expect one done pulse at GATE_CYCLES+1 after GATE entry, digits B,B,3,7, overflow = 0. Zero edges in the next window -> B,B,B,0.
- Carry chain: GATE_CYCLES = 2500, osc_in period 4 clk (625 edges/window). Second window -> B,6,2,5. With BLANK_LZ = 0 -> 0,6,2,5. Edge at 0999 -> 1000 in one cycle checked by probing the internal counter.
- Overflow: GATE_CYCLES = 50000, osc_in period 4 clk (12500 edges). Expect overflow = 1 and digits A,B,B,B. Next window with 10 edges -> overflow = 0, digits B,B,1,0.
- run abort: drop run mid-GATE -> busy falls next cycle, no done, digits hold their previous values. Raise run -> new full window, done after GATE_CYCLES+1 cycles.
- Reset mid-GATE: after 20 counted edges, assert reset 1 cycle -> next cycle digits C,C,C,C, state IDLE, no done.

Source files
------------

// File: rtl/freq_count_bcd.sv
// Gated frequency counter: counts synchronized rising edges of osc_in over GATE_CYCLES clocks
// in a 4-digit saturating BCD counter and latches display digit codes at the end of each window.
module freq_count_bcd #(
   parameter int unsigned GATE_CYCLES = 100_000_000,
   parameter int unsigned GATE_W      = 27,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       osc_in,
   output logic [3:0] dig0,
   output logic [3:0] dig1,
   output logic [3:0] dig2,
   output logic [3:0] dig3,
   output logic       done,
   output logic       overflow,
   output logic       busy
);

   localparam logic [3:0]        CODE_E     = 4'hA;
   localparam logic [3:0]        CODE_BLANK = 4'hB;
   localparam logic [3:0]        CODE_DASH  = 4'hC;
   localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      GATE,
      LATCH
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              s1;
   logic              s2;
   logic              s3;
   logic              rise;
   logic [GATE_W-1:0] gate_cnt;
   logic              gate_last;
   logic [3:0][3:0]   bcd;
   logic              bcd_max;
   logic              ovf;
   logic [3:0][3:0]   shown;
   logic              lead;

   // Ripple-carry increment of a 4-digit BCD value, digit 0 least significant.
   function automatic logic [3:0][3:0] bcd_inc(input logic [3:0][3:0] value);
      logic [3:0][3:0] result;
      logic            carry;
      result = value;
      carry  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (result[i] == 4'd9) begin
               result[i] = 4'd0;
            end else begin
               result[i] = result[i] + 4'd1;
               carry     = 1'b0;
            end
         end
      end
      return result;
   endfunction

   // NOTE: non-blocking assignments make s1 -> s2 -> s3 shift exactly one stage per clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= osc_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise      = s2 & ~s3;
   assign gate_last = (gate_cnt == GATE_LAST);
   assign bcd_max   = (bcd == 16'h9999);
   assign busy      = (state == GATE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (run) state_next = GATE;
         GATE: begin
            if (!run) begin
               state_next = IDLE;
            end else if (gate_last) begin
               state_next = LATCH;
            end
         end
         LATCH:   state_next = run ? GATE : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gate_cnt <= '0;
      end else if (state == GATE) begin
         gate_cnt <= gate_cnt + GATE_W'(1);
      end else begin
         gate_cnt <= '0;
      end
   end

   // Counter only runs in GATE; IDLE holds it cleared and LATCH discards its rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         bcd <= '0;
         ovf <= 1'b0;
      end else if (state == GATE) begin
         if (rise) begin
            if (bcd_max) begin
               ovf <= 1'b1;
            end else begin
               bcd <= bcd_inc(bcd);
            end
         end
      end else begin
         bcd <= '0;
         ovf <= 1'b0;
      end
   end

   always_comb begin
      shown = bcd;
      lead  = BLANK_LZ;
      if (ovf) begin
         shown = {CODE_E, CODE_BLANK, CODE_BLANK, CODE_BLANK};
      end else begin
         for (int i = 3; i >= 1; i--) begin
            if (lead && (bcd[i] == 4'd0)) begin
               shown[i] = CODE_BLANK;
            end else begin
               lead = 1'b0;
            end
         end
      end
   end

   // Display registers change only on the edge leaving LATCH, so aborted windows leave them intact.
   always_ff @(posedge clk) begin
      if (reset) begin
         dig0     <= CODE_DASH;
         dig1     <= CODE_DASH;
         dig2     <= CODE_DASH;
         dig3     <= CODE_DASH;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= (state == LATCH);
         if (state == LATCH) begin
            dig0     <= shown[0];
            dig1     <= shown[1];
            dig2     <= shown[2];
            dig3     <= shown[3];
            overflow <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_freq_count_bcd.sv
// Self-checking bench for freq_count_bcd: four instances (short, carry x2, overflow windows)
// driven from a directed vector table, hand sequences and randomized windows checked against a model.
module tb_freq_count_bcd;

   localparam int G_A = 200;
   localparam int G_B = 2500;
   localparam int G_C = 30300;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, run_a, osc_a, done_a, ovf_a, busy_a;
   logic [3:0] a_d0, a_d1, a_d2, a_d3;
   logic       reset_b, run_b, osc_b;
   logic       done_b1, ovf_b1, busy_b1, done_b0, ovf_b0, busy_b0;
   logic [3:0] b1_d0, b1_d1, b1_d2, b1_d3, b0_d0, b0_d1, b0_d2, b0_d3;
   logic       reset_c, run_c, osc_c, done_c, ovf_c, busy_c;
   logic [3:0] c_d0, c_d1, c_d2, c_d3;

   logic [15:0] a_digs, b1_digs, b0_digs, c_digs;
   assign a_digs  = {a_d3, a_d2, a_d1, a_d0};
   assign b1_digs = {b1_d3, b1_d2, b1_d1, b1_d0};
   assign b0_digs = {b0_d3, b0_d2, b0_d1, b0_d0};
   assign c_digs  = {c_d3, c_d2, c_d1, c_d0};

   freq_count_bcd #(.GATE_CYCLES(G_A), .GATE_W(8), .BLANK_LZ(1'b1)) u_a (
      .clk(clk), .reset(reset_a), .run(run_a), .osc_in(osc_a),
      .dig0(a_d0), .dig1(a_d1), .dig2(a_d2), .dig3(a_d3),
      .done(done_a), .overflow(ovf_a), .busy(busy_a));

   freq_count_bcd #(.GATE_CYCLES(G_B), .GATE_W(12), .BLANK_LZ(1'b1)) u_b1 (
      .clk(clk), .reset(reset_b), .run(run_b), .osc_in(osc_b),
      .dig0(b1_d0), .dig1(b1_d1), .dig2(b1_d2), .dig3(b1_d3),
      .done(done_b1), .overflow(ovf_b1), .busy(busy_b1));

   freq_count_bcd #(.GATE_CYCLES(G_B), .GATE_W(12), .BLANK_LZ(1'b0)) u_b0 (
      .clk(clk), .reset(reset_b), .run(run_b), .osc_in(osc_b),
      .dig0(b0_d0), .dig1(b0_d1), .dig2(b0_d2), .dig3(b0_d3),
      .done(done_b0), .overflow(ovf_b0), .busy(busy_b0));

   freq_count_bcd #(.GATE_CYCLES(G_C), .GATE_W(15), .BLANK_LZ(1'b1)) u_c (
      .clk(clk), .reset(reset_c), .run(run_c), .osc_in(osc_c),
      .dig0(c_d0), .dig1(c_d1), .dig2(c_d2), .dig3(c_d3),
      .done(done_c), .overflow(ovf_c), .busy(busy_c));

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Expected {overflow, dig3..dig0} for n counted edges, straight from the display rules.
   function automatic logic [16:0] model_out(input int n, input bit blank_lz);
      logic [3:0] d [4];
      int         m;
      bit         lead;
      if (n > 9999) return {1'b1, 4'hA, 4'hB, 4'hB, 4'hB};
      m = n;
      for (int i = 0; i < 4; i++) begin
         d[i] = 4'(m % 10);
         m    = m / 10;
      end
      lead = blank_lz;
      for (int i = 3; i >= 1; i--) begin
         if (lead && d[i] == 4'd0) d[i] = 4'hB;
         else lead = 1'b0;
      end
      return {1'b0, d[3], d[2], d[1], d[0]};
   endfunction

   // Called on the first GATE cycle (done just seen); takes exactly 2 + n*spacing cycles.
   task automatic a_drive_edges(input int n, input int spacing);
      @(negedge clk);
      check("a_done_width", done_a, 1'b0);
      @(negedge clk);
      for (int k = 0; k < n; k++) begin
         osc_a = 1'b1;
         @(negedge clk);
         osc_a = 1'b0;
         repeat (spacing - 1) @(negedge clk);
      end
   endtask

   task automatic a_wait_done(input int limit, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done_a && cyc < limit);
      if (!done_a) cyc = -1;
   endtask

   typedef struct {
      int          n;
      int          spacing;
      logic [15:0] digs;
      logic        ovf;
   } a_vec_t;

   a_vec_t vecs [7];

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad_busy, bad_done;

      vecs[0] = '{37, 4, 16'hBB37, 1'b0};
      vecs[1] = '{0,  4, 16'hBBB0, 1'b0};
      vecs[2] = '{9,  3, 16'hBBB9, 1'b0};
      vecs[3] = '{10, 5, 16'hBB10, 1'b0};
      vecs[4] = '{50, 3, 16'hBB50, 1'b0};
      vecs[5] = '{1,  6, 16'hBBB1, 1'b0};
      vecs[6] = '{21, 7, 16'hBB21, 1'b0};

      reset_a = 1'b1; run_a = 1'b0; osc_a = 1'b0;
      reset_b = 1'b1; run_b = 1'b0; osc_b = 1'b0;
      reset_c = 1'b1; run_c = 1'b0; osc_c = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         osc_a = ~osc_a; osc_b = ~osc_b; osc_c = ~osc_c;
      end
      check("rst_a_digs", a_digs, 16'hCCCC);
      check("rst_b1_digs", b1_digs, 16'hCCCC);
      check("rst_b0_digs", b0_digs, 16'hCCCC);
      check("rst_c_digs", c_digs, 16'hCCCC);
      check("rst_a_flags", {done_a, ovf_a, busy_a}, 3'b000);
      check("rst_c_flags", {done_c, ovf_c, busy_c}, 3'b000);
      reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
      osc_a = 1'b0; osc_b = 1'b0; osc_c = 1'b0;

      bad_busy = 1'b0; bad_done = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (busy_a || busy_b1 || busy_c) bad_busy = 1'b1;
         if (done_a || done_b1 || done_c) bad_done = 1'b1;
      end
      check("idle_busy", bad_busy, 1'b0);
      check("idle_done", bad_done, 1'b0);
      check("idle_a_digs", a_digs, 16'hCCCC);

      fork
         begin : branch_a
            int          cyc, w, n, s;
            logic [16:0] exp_out;
            logic [15:0] last_digs;
            bit          saw_done;

            run_a = 1'b1;
            a_wait_done(G_A + 20, cyc);
            check("a_first_latency", cyc, G_A + 2);
            check("a_first_digs", a_digs, 16'hBBB0);

            for (int i = 0; i < 7; i++) begin
               a_drive_edges(vecs[i].n, vecs[i].spacing);
               a_wait_done(G_A + 20, w);
               cyc = (w < 0) ? -1 : 2 + vecs[i].n * vecs[i].spacing + w;
               check($sformatf("vec%0d_period", i), cyc, G_A + 1);
               check($sformatf("vec%0d_digs", i), a_digs, vecs[i].digs);
               check($sformatf("vec%0d_ovf", i), ovf_a, vecs[i].ovf);
            end

            last_digs = a_digs;
            for (int r = 0; r < 20; r++) begin
               s = int'($urandom_range(3, 7));
               n = int'($urandom_range(0, 150 / s));
               a_drive_edges(n, s);
               a_wait_done(G_A + 20, w);
               exp_out = model_out(n, 1'b1);
               check($sformatf("rnd%0d_n%0d_digs", r, n), a_digs, exp_out[15:0]);
               check($sformatf("rnd%0d_n%0d_ovf", r, n), ovf_a, exp_out[16]);
               last_digs = exp_out[15:0];
            end

            // Abort mid-window: busy drops, no done, display holds.
            a_drive_edges(15, 4);
            run_a = 1'b0;
            @(negedge clk);
            check("abort_busy", busy_a, 1'b0);
            saw_done = 1'b0;
            repeat (30) begin
               @(negedge clk);
               if (done_a) saw_done = 1'b1;
            end
            check("abort_no_done", saw_done, 1'b0);
            check("abort_digs_hold", a_digs, last_digs);
            run_a = 1'b1;
            a_wait_done(G_A + 20, cyc);
            check("rerun_latency", cyc, G_A + 2);
            check("rerun_digs", a_digs, 16'hBBB0);

            // Reset mid-window after 20 counted edges.
            a_drive_edges(20, 4);
            repeat (4) @(negedge clk);
            reset_a = 1'b1;
            @(negedge clk);
            reset_a = 1'b0;
            check("midrst_digs", a_digs, 16'hCCCC);
            check("midrst_flags", {done_a, ovf_a, busy_a}, 3'b000);
            check("midrst_bcd", u_a.bcd, 16'h0000);
            a_wait_done(G_A + 20, cyc);
            check("midrst_latency", cyc, G_A + 2);
            check("midrst_next_digs", a_digs, 16'hBBB0);
         end

         begin : branch_b
            int ph, cyc;
            ph = 0;
            repeat (10) begin
               @(negedge clk);
               osc_b = (ph == 0);
               ph = (ph + 1) % 4;
            end
            run_b = 1'b1;
            for (int w = 0; w < 2; w++) begin
               cyc = 0;
               while (cyc < G_B + 20) begin
                  @(negedge clk);
                  cyc++;
                  osc_b = (ph == 0);
                  ph = (ph + 1) % 4;
                  if (done_b1) break;
               end
               check($sformatf("b_win%0d_latency", w), cyc, (w == 0) ? G_B + 2 : G_B + 1);
               check($sformatf("b_win%0d_done0", w), done_b0, 1'b1);
               check($sformatf("b_win%0d_blank_digs", w), b1_digs, 16'hB625);
               check($sformatf("b_win%0d_zero_digs", w), b0_digs, 16'h0625);
               check($sformatf("b_win%0d_ovf", w), {ovf_b1, ovf_b0}, 2'b00);
            end
            run_b = 1'b0;
            osc_b = 1'b0;
         end

         begin : branch_c
            int          ph, cyc;
            logic [15:0] prev, cur;
            bit          seen_carry, seen_ovf;
            ph = 0; seen_carry = 1'b0; seen_ovf = 1'b0;
            repeat (10) begin
               @(negedge clk);
               osc_c = (ph == 0);
               ph = (ph + 1) % 3;
            end
            run_c = 1'b1;
            cyc   = 0;
            prev  = u_c.bcd;
            while (cyc < G_C + 20) begin
               @(negedge clk);
               cyc++;
               cur = u_c.bcd;
               if (prev == 16'h0999 && cur != 16'h0999) begin
                  check("c_carry_0999", cur, 16'h1000);
                  seen_carry = 1'b1;
               end
               if (u_c.ovf && !seen_ovf) begin
                  check("c_saturate", cur, 16'h9999);
                  seen_ovf = 1'b1;
               end
               prev = cur;
               if (done_c) break;
               if (cyc < G_C - 10) begin
                  osc_c = (ph == 0);
                  ph = (ph + 1) % 3;
               end else begin
                  osc_c = 1'b0;
               end
            end
            check("c_latency", cyc, G_C + 2);
            check("c_ovf_digs", c_digs, 16'hABBB);
            check("c_ovf_flag", ovf_c, 1'b1);
            check("c_carry_seen", seen_carry, 1'b1);
            check("c_ovf_seen", seen_ovf, 1'b1);

            osc_c = 1'b0;
            cyc   = 0;
            repeat (2) begin @(negedge clk); cyc++; end
            for (int k = 0; k < 10; k++) begin
               osc_c = 1'b1;
               @(negedge clk); cyc++;
               osc_c = 1'b0;
               repeat (4) begin @(negedge clk); cyc++; end
            end
            while (!done_c && cyc < G_C + 20) begin
               @(negedge clk);
               cyc++;
            end
            check("c2_period", cyc, G_C + 1);
            check("c2_digs", c_digs, 16'hBB10);
            check("c2_ovf", ovf_c, 1'b0);
         end
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
